// File: rtl/fib_run_controller_if.sv
// fib_run_controller_if: host load, core control and result signals.
// master = host/core side, slave = controller side.
// Optional cycle_count member when FIB_RUN_CYCLE_COUNT_EN is defined.
`timescale 1ns/1ps
interface fib_run_controller_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 6
);
    logic                  start;
    logic [ADDR_W:0]       prog_len;
    logic                  prog_valid;
    logic                  prog_ready;
    logic [DATA_WIDTH-1:0] prog_data;
    logic                  imem_we;
    logic [ADDR_W-1:0]     imem_waddr;
    logic [DATA_WIDTH-1:0] imem_wdata;
    logic                  core_rst;
    logic                  core_run;
    logic [DATA_WIDTH-1:0] instr_in;
    logic [4:0]            dbg_raddr;
    logic [DATA_WIDTH-1:0] dbg_rdata;
    logic [DATA_WIDTH-1:0] result;
    logic                  busy;
    logic                  done;
    logic                  timeout;
`ifdef FIB_RUN_CYCLE_COUNT_EN
    logic [31:0]           cycle_count;
`endif

    modport master (
`ifdef FIB_RUN_CYCLE_COUNT_EN
        input  cycle_count,
`endif
        output start, prog_len, prog_valid, prog_data,
        output instr_in, dbg_rdata,
        input  prog_ready, imem_we, imem_waddr, imem_wdata,
        input  core_rst, core_run, dbg_raddr,
        input  result, busy, done, timeout
    );

    modport slave (
`ifdef FIB_RUN_CYCLE_COUNT_EN
        output cycle_count,
`endif
        input  start, prog_len, prog_valid, prog_data,
        input  instr_in, dbg_rdata,
        output prog_ready, imem_we, imem_waddr, imem_wdata,
        output core_rst, core_run, dbg_raddr,
        output result, busy, done, timeout
    );
endinterface

// File: rtl/fib_run_controller.sv
// fib_run_controller: loads a program into the core's instruction memory,
// pulses core reset, runs until halt (jal x0,0) or MAX_CYCLES, then reads
// RESULT_REG and pulses done.
// Ports: clk, rst (sync, active-high), bus (fib_run_controller_if.slave):
//   host side start/prog_len/prog_valid/prog_ready/prog_data,
//   imem write port, core_rst/core_run, instr_in, dbg read port,
//   result/busy/done/timeout.
// Optional: FIB_RUN_CYCLE_COUNT_EN adds bus.cycle_count (saturating).
`timescale 1ns/1ps
module fib_run_controller #(
    parameter int DATA_WIDTH = 32,
    parameter int IMEM_DEPTH = 64,
    parameter int ADDR_W     = $clog2(IMEM_DEPTH),
    parameter int MAX_CYCLES = 4096,
    parameter int RESULT_REG = 10,
    parameter logic [DATA_WIDTH-1:0] HALT_INSTR = 'h0000006F
) (
    input logic                 clk,
    input logic                 rst,
    fib_run_controller_if.slave bus
);
    localparam int CYC_W = $clog2(MAX_CYCLES + 1);
    localparam int AW1   = ADDR_W + 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(MAX_CYCLES - 1);
    localparam logic [AW1-1:0]   DEPTH    = AW1'(IMEM_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CLEAR, S_RUN, S_READ, S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [AW1-1:0]        addr_q, addr_d;
    logic [AW1-1:0]        len_q, len_d;
    logic [CYC_W-1:0]      cyc_q, cyc_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  timeout_q, timeout_d;
    logic                  load_rdy;
    logic                  hs;

    // Reset gates the handshake so an aborted load never writes memory.
    assign load_rdy = (state_q == S_LOAD) & ~rst;
    assign hs       = load_rdy & bus.prog_valid;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cyc_d     = cyc_q;
        result_d  = result_q;
        timeout_d = timeout_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    timeout_d = 1'b0;
                    addr_d    = '0;
                    len_d     = (bus.prog_len > DEPTH) ? DEPTH
                                                       : bus.prog_len;
                    state_d   = (bus.prog_len == '0) ? S_CLEAR : S_LOAD;
                end
            end
            S_LOAD: begin
                if (hs) begin
                    addr_d = addr_q + 1'b1;
                    if (addr_q == len_q - 1'b1) state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                cyc_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                cyc_d = cyc_q + 1'b1;
                // Halt takes priority over the limit on the same cycle.
                if (bus.instr_in == HALT_INSTR) begin
                    state_d = S_READ;
                end else if (cyc_q == CYC_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_READ;
                end
            end
            S_READ: begin
                result_d = bus.dbg_rdata;
                state_d  = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            cyc_q     <= '0;
            result_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cyc_q     <= cyc_d;
            result_q  <= result_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.prog_ready = load_rdy;
    assign bus.imem_we    = hs;
    assign bus.imem_waddr = addr_q[ADDR_W-1:0];
    assign bus.imem_wdata = bus.prog_data;
    // Core stays parked in reset while idle.
    assign bus.core_rst   = rst | (state_q == S_IDLE)
                                | (state_q == S_CLEAR);
    assign bus.core_run   = (state_q == S_RUN) & ~rst;
    assign bus.dbg_raddr  = 5'(RESULT_REG);
    assign bus.result     = result_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_DONE) & ~rst;
    assign bus.timeout    = timeout_q;

`ifdef FIB_RUN_CYCLE_COUNT_EN
    logic [31:0] ccnt_q, ccnt_d;

    always_comb begin
        ccnt_d = ccnt_q;
        if (state_d == S_CLEAR && state_q != S_CLEAR) begin
            ccnt_d = '0;
        end else if (state_q == S_RUN && ccnt_q != '1) begin
            ccnt_d = ccnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ccnt_q <= '0;
        else     ccnt_q <= ccnt_d;
    end

    assign bus.cycle_count = ccnt_q;
`endif
endmodule
